frame_align_ctrl: RTL

FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

---
 rtl/frame_align_pkg.sv | 29 ++
 rtl/frame_align_ctrl_match.sv | 37 +++
 rtl/frame_align_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/frame_align_pkg.sv
// Shared types and constants for the frame-lane alignment controller.
package frame_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    SLIP,
    SETTLE,
    VERIFY,
    LOCKED,
    FAIL
  } frmState_t;

  localparam int SlipCntW   = 4;
  localparam int SettleCntW = 4;
  localparam int MatchCntW  = 8;
  localparam int MissCntW   = 8;

  // Frame word the ADC emits for each supported resolution.
  function automatic logic [15:0] frmDefaultPattern(input int adcBits);
    case (adcBits)
      8:       return 16'h00F0;
      10:      return 16'h03E0;
      12:      return 16'h0FC0;
      default: return 16'h3F80;
    endcase
  endfunction

endpackage

// File: rtl/frame_align_ctrl_match.sv
// Registered frame-word compare with consecutive match and mismatch counters.
module frame_word_match
  import frame_align_pkg::*;
#(
  parameter int                 AdcBits = 14,
  parameter logic [AdcBits-1:0] Pattern = '0
) (
  input  logic                 DatClkDiv,
  input  logic                 DatRst,
  input  logic [AdcBits-1:0]   frmWord,
  input  logic                 matchEn,
  input  logic                 missEn,
  output logic                 wordMatch,
  output logic [MatchCntW-1:0] matchCnt,
  output logic [MissCntW-1:0]  missCnt
);

  logic [AdcBits-1:0] wordQ;

  assign wordMatch = (wordQ == Pattern);

  // Counters clear whenever their enable is low, so each run starts from zero.
  always_ff @(posedge DatClkDiv or posedge DatRst) begin
    if (DatRst) begin
      wordQ    <= '0;
      matchCnt <= '0;
      missCnt  <= '0;
    end else begin
      wordQ <= frmWord;
      if (!matchEn || !wordMatch) matchCnt <= '0;
      else if (matchCnt != '1)    matchCnt <= matchCnt + 1'b1;
      if (!missEn || wordMatch)   missCnt <= '0;
      else if (missCnt != '1)     missCnt <= missCnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_align_ctrl.sv
// Frame-lane bitslip alignment controller for a deserialized ADC link.
// Optional lock-loss monitor enabled by defining FRM_LOCK_MONITOR_EN.
module frame_align_ctrl
  import frame_align_pkg::*;
#(
  parameter int          AdcBits      = 14,
  parameter logic [15:0] FrmPattern   = frmDefaultPattern(AdcBits),
  parameter int          SettleCycles = 4,
  parameter int          MaxSlips     = 14,
  parameter int          LockCount    = 8,
  parameter int          LossCount    = 4
) (
  input  logic                DatClkDiv,
  input  logic                DatRst,
  input  logic [15:0]         FrmData,
  input  logic                AlignStart,
  output logic                FrmBitslip,
  output logic                FrmAlignDone,
  output logic                FrmAlignFail,
  output logic [SlipCntW-1:0] SlipCount,
  output logic                FrmLockLost
);

  localparam logic [SettleCntW-1:0] SettleLast = SettleCntW'(SettleCycles - 1);
  localparam logic [SlipCntW-1:0]   SlipLimit  = SlipCntW'(MaxSlips);
  localparam logic [MatchCntW-1:0]  LockLast   = MatchCntW'(LockCount - 1);

  frmState_t              state, stateNext;
  logic [SlipCntW-1:0]    slipNext;
  logic [SettleCntW-1:0]  settleCnt, settleNext;
  logic                   wordMatch, matchEn, missEn;
  logic [MatchCntW-1:0]   matchCnt;
  logic [MissCntW-1:0]    missCnt;
  logic                   unusedHighBits;

  assign unusedHighBits = ^FrmData[15:AdcBits];
  assign matchEn = (state == COMPARE) || (state == VERIFY);

  frame_word_match #(
    .AdcBits (AdcBits),
    .Pattern (FrmPattern[AdcBits-1:0])
  ) uMatch (
    .DatClkDiv (DatClkDiv),
    .DatRst    (DatRst),
    .frmWord   (FrmData[AdcBits-1:0]),
    .matchEn   (matchEn),
    .missEn    (missEn),
    .wordMatch (wordMatch),
    .matchCnt  (matchCnt),
    .missCnt   (missCnt)
  );

`ifdef FRM_LOCK_MONITOR_EN
  localparam logic [MissCntW-1:0] LossLast = MissCntW'(LossCount - 1);
  logic lostNext;
  assign missEn = (state == LOCKED);
`else
  logic unusedMissCnt;
  assign missEn        = 1'b0;
  assign unusedMissCnt = ^missCnt;
  assign FrmLockLost   = 1'b0;
`endif

  always_comb begin
    stateNext  = state;
    slipNext   = SlipCount;
    settleNext = '0;
`ifdef FRM_LOCK_MONITOR_EN
    lostNext   = 1'b0;
`endif
    case (state)
      SETTLE: begin
        if (settleCnt == SettleLast) stateNext = COMPARE;
        else                         settleNext = settleCnt + 1'b1;
      end
      COMPARE: begin
        if (wordMatch) stateNext = (LockCount <= 1) ? LOCKED : VERIFY;
        else           stateNext = (SlipCount < SlipLimit) ? SLIP : FAIL;
      end
      SLIP: begin
        if (SlipCount != '1) slipNext = SlipCount + 1'b1;
        stateNext = SETTLE;
      end
      VERIFY: begin
        if (wordMatch) begin
          if (matchCnt == LockLast) stateNext = LOCKED;
        end else begin
          stateNext = (SlipCount < SlipLimit) ? SLIP : FAIL;
        end
      end
`ifdef FRM_LOCK_MONITOR_EN
      LOCKED: begin
        if (!wordMatch && (missCnt == LossLast)) begin
          stateNext = COMPARE;
          slipNext  = '0;
          lostNext  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    // Restart overrides whatever the current state decided, including a pending slip.
    if (AlignStart) begin
      stateNext  = SETTLE;
      slipNext   = '0;
      settleNext = '0;
`ifdef FRM_LOCK_MONITOR_EN
      lostNext   = 1'b0;
`endif
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge DatClkDiv or posedge DatRst) begin
    if (DatRst) begin
      state        <= IDLE;
      SlipCount    <= '0;
      settleCnt    <= '0;
      FrmBitslip   <= 1'b0;
      FrmAlignDone <= 1'b0;
      FrmAlignFail <= 1'b0;
    end else begin
      state        <= stateNext;
      SlipCount    <= slipNext;
      settleCnt    <= settleNext;
      FrmBitslip   <= (stateNext == SLIP);
      FrmAlignDone <= (stateNext == LOCKED);
      FrmAlignFail <= (stateNext == FAIL);
    end
  end

`ifdef FRM_LOCK_MONITOR_EN
  always_ff @(posedge DatClkDiv or posedge DatRst) begin
    if (DatRst) FrmLockLost <= 1'b0;
    else        FrmLockLost <= lostNext;
  end
`endif

endmodule
